// File: rtl/mul_hi_sequencer_pkg.sv
// Shared types for the multi-pass MUL/MULH* sequencer.
// Op encodings, FSM states and operand split width.
package mul_pkg;

    localparam int XLEN = 32;
    localparam int HALF = 16;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        FIX,
        DONE
    } mul_state_e;

    function automatic logic op_a_signed(mul_op_e op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(mul_op_e op);
        return op == MUL_OP_MULH;
    endfunction

endpackage

// File: rtl/mul_hi_sequencer_if.sv
// Request/response handshake bundle for the multiply sequencer.
// master = requester, slave = sequencer.
interface mul_hi_sequencer_if;
    import mul_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/mul_hi_sequencer_sign_fix.sv
// Conditional two's-complement negate; used for |x| on the
// operands and for re-applying the sign to the accumulator.
module mul_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_hi_sequencer.sv
// Drives an external 32x32->32 multiplier through one pass (MUL)
// or four 16x16 passes (high products) plus a sign fix-up.
module mul_hi_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mul_hi_sequencer_if.slave bus,
    output logic [XLEN-1:0]  mul_a,
    output logic [XLEN-1:0]  mul_b,
    input  logic [XLEN-1:0]  mul_prod
);

    if (WIDTH != XLEN) begin : g_width_check
        $error("mul_hi_sequencer: only WIDTH=32 is supported");
    end

    mul_state_e      state_q;
    mul_op_e         op_q;
    logic [1:0]      cnt_q;
    logic            neg_q;
    logic [XLEN-1:0] a_mag_q;
    logic [XLEN-1:0] b_mag_q;
    logic [63:0]     acc_q;
    logic [XLEN-1:0] res_q;
    logic            ovalid_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;

    mul_op_e         op_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic            neg_d;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [63:0]     acc_fix;
    logic            accept;
    logic            fast;
    logic [XLEN-1:0] pa;
    logic [XLEN-1:0] pb;
    logic [63:0]     addend;

    assign op_in    = mul_op_e'(bus.in_op);
    assign a_neg_in = op_a_signed(op_in) & bus.in_a[XLEN-1];
    assign b_neg_in = op_b_signed(op_in) & bus.in_b[XLEN-1];
    assign neg_d    = a_neg_in ^ b_neg_in;

    mul_sign_fix #(.W(XLEN)) u_abs_a (
        .val_i (bus.in_a),
        .neg_i (a_neg_in),
        .val_o (a_abs)
    );

    mul_sign_fix #(.W(XLEN)) u_abs_b (
        .val_i (bus.in_b),
        .neg_i (b_neg_in),
        .val_o (b_abs)
    );

    mul_sign_fix #(.W(64)) u_fix_acc (
        .val_i (acc_q),
        .neg_i (neg_q),
        .val_o (acc_fix)
    );

    assign bus.in_ready   = !rst && (state_q == IDLE);
    assign bus.out_valid  = ovalid_q;
    assign bus.out_result = res_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign fast   = FAST_MUL && (op_q == MUL_OP_MUL);

    // cnt[1] picks the A half, cnt[0] the B half
    always_comb begin
        pa     = cnt_q[1] ? XLEN'(a_mag_q[XLEN-1:HALF])
                          : XLEN'(a_mag_q[HALF-1:0]);
        pb     = cnt_q[0] ? XLEN'(b_mag_q[XLEN-1:HALF])
                          : XLEN'(b_mag_q[HALF-1:0]);
        if (fast) begin
            pa = a_mag_q;
            pb = b_mag_q;
        end
        addend = '0;
        unique case (cnt_q)
            2'd0:       addend = {32'b0, mul_prod};
            2'd1, 2'd2: addend = {16'b0, mul_prod, 16'b0};
            2'd3:       addend = {mul_prod, 32'b0};
            default:    addend = '0;
        endcase
    end

    assign mul_a = (state_q == PASS) ? pa : mul_a_q;
    assign mul_b = (state_q == PASS) ? pb : mul_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= MUL_OP_MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            ovalid_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            mul_a_q <= mul_a;
            mul_b_q <= mul_b;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        neg_q   <= neg_d;
                        a_mag_q <= a_abs;
                        b_mag_q <= b_abs;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= PASS;
                    end
                end
                PASS: begin
                    if (fast) begin
                        res_q    <= mul_prod;
                        ovalid_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        acc_q <= acc_q + addend;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_q <= FIX;
                    end
                end
                FIX: begin
                    acc_q    <= acc_fix;
                    res_q    <= (op_q == MUL_OP_MUL) ? acc_fix[31:0]
                                                     : acc_fix[63:32];
                    ovalid_q <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ovalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
